// File: rtl/trap_unit_if.sv
// trap_unit_if: exception, CSR and redirect signals between the pipeline and the trap unit
interface trap_unit_if #(parameter int XLEN = 64);
   logic [5:0]      exc_code;
   logic [XLEN-1:0] exc_pc;
   logic [XLEN-1:0] exc_tval;
   logic            mret;
   logic            csr_we;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            flush;
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            busy;
   modport master (
      output exc_code, exc_pc, exc_tval, mret, csr_we, csr_addr, csr_wdata,
      input  csr_rdata, flush, stall, redirect_valid, redirect_pc, busy
   );
   modport slave (
      input  exc_code, exc_pc, exc_tval, mret, csr_we, csr_addr, csr_wdata,
      output csr_rdata, flush, stall, redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap sequencer with mret and trap CSR file
module trap_unit #(
   parameter int              XLEN      = 64,
   parameter logic [XLEN-1:0] RESET_VEC = '0
) (
   input logic        clk,
   input logic        reset,
   trap_unit_if.slave t
);
   typedef enum logic [2:0] {IDLE, FLUSH, COMMIT, REDIRECT, RET} state_t;
   localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
   state_t          state, state_nx;
   logic [5:0]      h_code;
   logic [XLEN-1:0] h_pc, h_tval, mtvec, mepc, mcause, mtval;
   logic            mie, mpie;
   logic            exc, wr;
   assign exc = t.exc_code != 6'h1F;
   assign wr  = state == IDLE && !exc && !t.mret && t.csr_we;
   // outputs decode only the state register, never the inputs
   always_comb begin
      state_nx         = IDLE;
      t.flush          = state == FLUSH;
      t.stall          = state == FLUSH || state == COMMIT || state == REDIRECT;
      t.redirect_valid = state == REDIRECT || state == RET;
      t.busy           = state != IDLE;
      t.redirect_pc    = state == REDIRECT ? (mtvec & ALIGN) : state == RET ? mepc : '0;
      case (state)
         IDLE:    state_nx = exc ? FLUSH : t.mret ? RET : IDLE;
         FLUSH:   state_nx = COMMIT;
         COMMIT:  state_nx = REDIRECT;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      t.csr_rdata = '0;
      case (t.csr_addr)
         12'h300: begin
            t.csr_rdata[3] = mie;
            t.csr_rdata[7] = mpie;
         end
         12'h305: t.csr_rdata = mtvec;
         12'h341: t.csr_rdata = mepc;
         12'h342: t.csr_rdata = mcause;
         12'h343: t.csr_rdata = mtval;
         default: t.csr_rdata = '0;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_code <= '0;
         h_pc   <= '0;
         h_tval <= '0;
         mtvec  <= RESET_VEC;
         mepc   <= '0;
         mcause <= '0;
         mtval  <= '0;
         mie    <= 1'b0;
         mpie   <= 1'b0;
      end else begin
         if (state == IDLE && exc) begin
            h_code <= t.exc_code;
            h_pc   <= t.exc_pc;
            h_tval <= t.exc_tval;
         end
         if (state == COMMIT) begin
            mcause <= XLEN'(h_code);
            mepc   <= h_pc & ALIGN;
            mtval  <= h_tval;
            mpie   <= mie;
            mie    <= 1'b0;
         end
         if (state == RET) begin
            mie  <= mpie;
            mpie <= 1'b1;
         end
         if (wr)
            case (t.csr_addr)
               12'h300: begin
                  mie  <= t.csr_wdata[3];
                  mpie <= t.csr_wdata[7];
               end
               12'h305: mtvec  <= t.csr_wdata;
               12'h341: mepc   <= t.csr_wdata & ALIGN;
               12'h342: mcause <= t.csr_wdata;
               12'h343: mtval  <= t.csr_wdata;
               default: ;
            endcase
      end
   end
endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed checks of trap entry, mret, CSR port and reset
module tb_trap_unit;
   localparam logic [63:0] RV = 64'h100;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   trap_unit_if #(64) bus ();
   trap_unit #(.XLEN(64), .RESET_VEC(RV)) dut (.clk(clk), .reset(reset), .t(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
      bus.csr_addr = a;
      #1;
      chk(tag, bus.csr_rdata, exp);
   endtask
   task automatic wr(input logic [11:0] a, input logic [63:0] d);
      bus.csr_we = 1'b1;
      bus.csr_addr = a;
      bus.csr_wdata = d;
      tick();
      bus.csr_we = 1'b0;
   endtask
   function automatic logic [63:0] outs();
      return {59'd0, bus.flush, bus.stall, bus.redirect_valid, bus.busy};
   endfunction
   // full trap: drive code for one edge, then step through FLUSH, COMMIT, REDIRECT
   task automatic trap(input logic [5:0] c, input logic [63:0] pc, input logic [63:0] tv);
      bus.exc_code = c;
      bus.exc_pc = pc;
      bus.exc_tval = tv;
      tick();
      bus.exc_code = 6'h1F;
      chk("trap_flush", outs(), 64'b1101);
      tick();
      chk("trap_commit", outs(), 64'b0101);
      tick();
      chk("trap_redirect", outs(), 64'b0111);
      tick();
      chk("trap_idle", outs(), 64'b0000);
   endtask
   initial begin
      bus.exc_code = 6'h1F;
      bus.exc_pc = '0;
      bus.exc_tval = '0;
      bus.mret = 1'b0;
      bus.csr_we = 1'b0;
      bus.csr_addr = '0;
      bus.csr_wdata = '0;
      repeat (2) tick();
      reset = 1'b1;
      rd("rst_mstatus", 12'h300, 64'h0);
      rd("rst_mtvec", 12'h305, RV);
      rd("rst_mepc", 12'h341, 64'h0);
      rd("rst_mcause", 12'h342, 64'h0);
      rd("rst_mtval", 12'h343, 64'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_outs", outs(), 64'h0);
         chk("idle_pc", bus.redirect_pc, 64'h0);
      end
      wr(12'h340, 64'hFFFF);
      rd("unmapped", 12'h340, 64'h0);
      wr(12'h300, '1);
      rd("mstatus_mask", 12'h300, 64'h88);
      wr(12'h300, 64'h0);
      wr(12'h341, 64'h1237);
      rd("mepc_align", 12'h341, 64'h1234);
      wr(12'h342, 64'h8000_0000_0000_0009);
      rd("mcause_full", 12'h342, 64'h8000_0000_0000_0009);
      wr(12'h305, 64'h8000_0001);
      rd("mtvec_wr", 12'h305, 64'h8000_0001);
      bus.exc_code = 6'h02;
      bus.exc_pc = 64'h1006;
      bus.exc_tval = 64'hDEAD;
      tick();
      bus.exc_code = 6'h1F;
      chk("t1_flush", outs(), 64'b1101);
      tick();
      chk("t1_commit", outs(), 64'b0101);
      tick();
      chk("t1_redirect", outs(), 64'b0111);
      chk("t1_pc", bus.redirect_pc, 64'h8000_0000);
      tick();
      chk("t1_idle", outs(), 64'h0);
      rd("t1_mcause", 12'h342, 64'h2);
      rd("t1_mepc", 12'h341, 64'h1004);
      rd("t1_mtval", 12'h343, 64'hDEAD);
      wr(12'h300, 64'h8);
      rd("mie_set", 12'h300, 64'h8);
      trap(6'h0B, 64'h2000, 64'h0);
      rd("ecall_mstatus", 12'h300, 64'h80);
      rd("ecall_mcause", 12'h342, 64'hB);
      bus.mret = 1'b1;
      tick();
      bus.mret = 1'b0;
      chk("ret_outs", outs(), 64'b0011);
      chk("ret_pc", bus.redirect_pc, 64'h2000);
      tick();
      chk("ret_idle", outs(), 64'h0);
      rd("ret_mstatus", 12'h300, 64'h88);
      bus.mret = 1'b1;
      bus.csr_we = 1'b1;
      bus.csr_addr = 12'h343;
      bus.csr_wdata = 64'h1234;
      trap(6'h05, 64'h3000, 64'hBEEF);
      bus.mret = 1'b0;
      bus.csr_we = 1'b0;
      rd("race_mtval", 12'h343, 64'hBEEF);
      rd("race_mcause", 12'h342, 64'h5);
      rd("race_mstatus", 12'h300, 64'h80);
      bus.exc_code = 6'h03;
      bus.exc_pc = 64'h4000;
      bus.exc_tval = 64'h33;
      tick();
      bus.exc_code = 6'h04;
      bus.exc_pc = 64'h5000;
      tick();
      bus.exc_code = 6'h1F;
      chk("ign_commit", outs(), 64'b0101);
      tick();
      bus.mret = 1'b1;
      tick();
      bus.mret = 1'b0;
      chk("ign_idle", outs(), 64'h0);
      tick();
      chk("ign_still_idle", outs(), 64'h0);
      rd("ign_mcause", 12'h342, 64'h3);
      rd("ign_mepc", 12'h341, 64'h4000);
      bus.exc_code = 6'h07;
      bus.exc_pc = 64'h6000;
      bus.exc_tval = 64'h77;
      tick();
      bus.exc_code = 6'h1F;
      tick();
      chk("rst_pre", outs(), 64'b0101);
      reset = 1'b0;
      #1;
      chk("rst_outs", outs(), 64'h0);
      chk("rst_pc", bus.redirect_pc, 64'h0);
      rd("rst2_mcause", 12'h342, 64'h0);
      rd("rst2_mepc", 12'h341, 64'h0);
      rd("rst2_mtval", 12'h343, 64'h0);
      rd("rst2_mtvec", 12'h305, RV);
      rd("rst2_mstatus", 12'h300, 64'h0);
      tick();
      reset = 1'b1;
      tick();
      chk("rst_after", outs(), 64'h0);
      rd("rst_after_mcause", 12'h342, 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
